// File: rtl/regfile_pkg.sv
// Shared constants and the read-source priority used by the parametrised register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 3;

    // Number of registers addressed by an addr_w-bit address.
    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    // Where a read port takes its value from this cycle.
    typedef enum logic [1:0] {
        SrcStored,
        SrcPortA,
        SrcPortB,
        SrcZero
    } rd_src_e;

    // Priority: hardwired zero, then port B bypass, then port A bypass, then the array.
    function automatic rd_src_e read_src(input logic bypass, input logic zero_hit,
                                         input logic hit_a, input logic hit_b);
        if (zero_hit) return SrcZero;
        if (bypass && hit_b) return SrcPortB;
        if (bypass && hit_a) return SrcPortA;
        return SrcStored;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard with two combinational lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic [ADDR_W-1:0] look1_i,
    input  logic [ADDR_W-1:0] look2_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             wr_hit1, wr_hit2;

    // Next busy state: a write clears, a new set overrides the clear, register 0 may be pinned.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((we_a_i && addr_a_i == ADDR_W'(i)) || (we_b_i && addr_b_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_i && set_addr_i == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end
            if (ZERO_REG && i == 0) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Busy flops, cleared asynchronously.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wr_hit1 = (we_a_i && addr_a_i == look1_i) || (we_b_i && addr_b_i == look1_i);
    assign wr_hit2 = (we_a_i && addr_a_i == look2_i) || (we_b_i && addr_b_i == look2_i);

    // A write landing this cycle resolves the pending state early when bypass is on.
    assign busy1_o = busy_q[look1_i] && !(BYPASS && wr_hit1) && !(ZERO_REG && look1_i == '0);
    assign busy2_o = busy_q[look2_i] && !(BYPASS && wr_hit2) && !(ZERO_REG && look2_i == '0);

endmodule

// File: rtl/regfile_param.sv
// Parametrised two-read, two-write register file with bypass and busy scoreboard.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter bit          ZERO_REG  = 1'b0,
    parameter bit          BYPASS    = 1'b1,
    parameter bit          SYNC_READ = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] a4,
    input  logic [DATA_W-1:0] wd2,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              busy1,
    output logic              busy2
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] eff1, eff2;
    rd_src_e           src1, src2;

    // Next array contents: port B applied after port A so it wins a collision.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (we && a3 == ADDR_W'(i)) mem_d[i] = wd1;
            if (we2 && a4 == ADDR_W'(i)) mem_d[i] = wd2;
            if (ZERO_REG && i == 0) mem_d[i] = '0;
        end
    end

    // Register array, cleared asynchronously so an in-flight write is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign src1 = read_src(BYPASS, ZERO_REG && a1 == '0, we && a3 == a1, we2 && a4 == a1);
    assign src2 = read_src(BYPASS, ZERO_REG && a2 == '0, we && a3 == a2, we2 && a4 == a2);

    // Effective read values for both ports.
    always_comb begin
        eff1 = mem_q[a1];
        eff2 = mem_q[a2];
        unique case (src1)
            SrcStored: eff1 = mem_q[a1];
            SrcPortA:  eff1 = wd1;
            SrcPortB:  eff1 = wd2;
            SrcZero:   eff1 = '0;
        endcase
        unique case (src2)
            SrcStored: eff2 = mem_q[a2];
            SrcPortA:  eff2 = wd1;
            SrcPortB:  eff2 = wd2;
            SrcZero:   eff2 = '0;
        endcase
    end

    if (SYNC_READ) begin : g_sync_read
        logic [DATA_W-1:0] rd1_q, rd2_q;

        // One-cycle registered read of the effective value.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rd1_q <= '0;
                rd2_q <= '0;
            end else begin
                rd1_q <= eff1;
                rd2_q <= eff2;
            end
        end

        assign rd1 = rd1_q;
        assign rd2 = rd2_q;
    end else begin : g_comb_read
        assign rd1 = eff1;
        assign rd2 = eff2;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clock_i    (clock),
        .reset_ni   (reset_n),
        .we_a_i     (we),
        .addr_a_i   (a3),
        .we_b_i     (we2),
        .addr_b_i   (a4),
        .set_i      (busy_set),
        .set_addr_i (busy_addr),
        .look1_i    (a1),
        .look2_i    (a2),
        .busy1_o    (busy1),
        .busy2_o    (busy2)
    );

endmodule

// File: tb/tb_regfile_param.sv
// Bench: two configurations driven in parallel and compared against a reference model.
module tb_regfile_param;

    logic       clock;
    logic       reset_n;
    logic [2:0] a1, a2, a3, a4, busy_addr;
    logic [7:0] wd1, wd2;
    logic       we, we2, busy_set;
    logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic       busy1_a, busy2_a, busy1_b, busy2_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference state: index 0 = default config, index 1 = zero-reg / no-bypass / sync-read.
    logic [7:0] mem_m  [2][8];
    bit         busy_m [2][8];
    bit         byp_p  [2] = '{1'b1, 1'b0};
    bit         zr_p   [2] = '{1'b0, 1'b1};

    typedef struct packed {
        logic [7:0] r1;
        logic [7:0] r2;
    } rd_pair_t;
    rd_pair_t sync_q[$];

    regfile_param #(
        .DATA_W (8), .ADDR_W (3), .ZERO_REG (1'b0), .BYPASS (1'b1), .SYNC_READ (1'b0)
    ) dut_a (
        .clock (clock), .reset_n (reset_n), .a1 (a1), .a2 (a2), .rd1 (rd1_a), .rd2 (rd2_a),
        .we (we), .a3 (a3), .wd1 (wd1), .we2 (we2), .a4 (a4), .wd2 (wd2),
        .busy_set (busy_set), .busy_addr (busy_addr), .busy1 (busy1_a), .busy2 (busy2_a)
    );

    regfile_param #(
        .DATA_W (8), .ADDR_W (3), .ZERO_REG (1'b1), .BYPASS (1'b0), .SYNC_READ (1'b1)
    ) dut_b (
        .clock (clock), .reset_n (reset_n), .a1 (a1), .a2 (a2), .rd1 (rd1_b), .rd2 (rd2_b),
        .we (we), .a3 (a3), .wd1 (wd1), .we2 (we2), .a4 (a4), .wd2 (wd2),
        .busy_set (busy_set), .busy_addr (busy_addr), .busy1 (busy1_b), .busy2 (busy2_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    endtask

    function automatic logic [7:0] exp_rd(input int k, input logic [2:0] x);
        logic [7:0] v;
        v = mem_m[k][x];
        if (byp_p[k]) begin
            if (we2 && a4 == x) v = wd2;
            else if (we && a3 == x) v = wd1;
        end
        if (zr_p[k] && x == 3'd0) v = 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] exp_busy(input int k, input logic [2:0] x);
        bit b;
        b = busy_m[k][x];
        if (byp_p[k] && ((we && a3 == x) || (we2 && a4 == x))) b = 1'b0;
        if (zr_p[k] && x == 3'd0) b = 1'b0;
        return {7'd0, b};
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (we) begin
                if (!(zr_p[k] && a3 == 3'd0)) mem_m[k][a3] = wd1;
                busy_m[k][a3] = 1'b0;
            end
            if (we2) begin
                if (!(zr_p[k] && a4 == 3'd0)) mem_m[k][a4] = wd2;
                busy_m[k][a4] = 1'b0;
            end
            if (busy_set && !(zr_p[k] && busy_addr == 3'd0)) busy_m[k][busy_addr] = 1'b1;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 8; r++) begin
                mem_m[k][r]  = 8'h00;
                busy_m[k][r] = 1'b0;
            end
        sync_q.delete();
        sync_q.push_back('{r1: 8'h00, r2: 8'h00});
    endtask

    // Entered just after a negedge with inputs applied; returns at the next negedge.
    task automatic step();
        rd_pair_t e;
        #2;
        check("a.rd1", rd1_a, exp_rd(0, a1));
        check("a.rd2", rd2_a, exp_rd(0, a2));
        check("a.busy1", 8'(busy1_a), exp_busy(0, a1));
        check("a.busy2", 8'(busy2_a), exp_busy(0, a2));
        check("b.busy1", 8'(busy1_b), exp_busy(1, a1));
        check("b.busy2", 8'(busy2_b), exp_busy(1, a2));
        e = sync_q.pop_front();
        check("b.rd1", rd1_b, e.r1);
        check("b.rd2", rd2_b, e.r2);
        e.r1 = exp_rd(1, a1);
        e.r2 = exp_rd(1, a2);
        sync_q.push_back(e);
        @(posedge clock);
        model_update();
        @(negedge clock);
        cyc++;
    endtask

    task automatic drive(input logic i_we, input logic [2:0] i_a3, input logic [7:0] i_wd1,
                         input logic i_we2, input logic [2:0] i_a4, input logic [7:0] i_wd2,
                         input logic i_bs, input logic [2:0] i_ba,
                         input logic [2:0] i_a1, input logic [2:0] i_a2);
        we = i_we; a3 = i_a3; wd1 = i_wd1;
        we2 = i_we2; a4 = i_a4; wd2 = i_wd2;
        busy_set = i_bs; busy_addr = i_ba;
        a1 = i_a1; a2 = i_a2;
        step();
    endtask

    task automatic idle(input logic [2:0] i_a1, input logic [2:0] i_a2);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, i_a1, i_a2);
    endtask

    // Entered at a negedge: a write is in flight when reset drops between edges.
    task automatic do_reset();
        we = 1'b1; a3 = 3'd3; wd1 = 8'h99;
        we2 = 1'b1; a4 = 3'd1; wd2 = 8'h77;
        busy_set = 1'b1; busy_addr = 3'd3;
        #2 reset_n = 1'b0;
        #1;
        we = 1'b0; we2 = 1'b0; busy_set = 1'b0;
        for (int x = 0; x < 8; x++) begin
            a1 = 3'(x);
            a2 = 3'(7 - x);
            #1;
            check("rst.a.rd1", rd1_a, 8'h00);
            check("rst.a.rd2", rd2_a, 8'h00);
            check("rst.a.busy1", 8'(busy1_a), 8'h00);
            check("rst.b.rd1", rd1_b, 8'h00);
            check("rst.b.rd2", rd2_b, 8'h00);
            check("rst.b.busy2", 8'(busy2_b), 8'h00);
        end
        model_clear();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        {we, we2, busy_set} = '0;
        {a1, a2, a3, a4, busy_addr} = '0;
        {wd1, wd2} = '0;
        model_clear();
        @(negedge clock);
        do_reset();

        // Basic write then read
        drive(1'b1, 3'd5, 8'hA7, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd5, 3'd0);
        idle(3'd5, 3'd0);
        idle(3'd5, 3'd5);

        // Same-cycle bypass
        drive(1'b1, 3'd2, 8'h3C, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd5);
        idle(3'd2, 3'd2);
        idle(3'd2, 3'd2);

        // Write collision: port B wins
        drive(1'b1, 3'd4, 8'h11, 1'b1, 3'd4, 8'h22, 1'b0, 3'd0, 3'd4, 3'd4);
        idle(3'd4, 3'd2);
        idle(3'd4, 3'd4);

        // Scoreboard set, hold, clear by load write
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6, 3'd6);
        idle(3'd6, 3'd6);
        idle(3'd6, 3'd5);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h55, 1'b0, 3'd0, 3'd6, 3'd6);
        idle(3'd6, 3'd6);
        idle(3'd6, 3'd6);

        // Set and write on the same register: set wins
        drive(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 3'd6, 3'd1);
        idle(3'd6, 3'd6);
        drive(1'b1, 3'd6, 8'h67, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd6);
        idle(3'd6, 3'd6);

        // Register 0: writable in default config, hardwired in the other
        drive(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0, 3'd0);
        idle(3'd0, 3'd0);
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hEE, 1'b1, 3'd0, 3'd0, 3'd0);
        idle(3'd0, 3'd0);
        idle(3'd0, 3'd6);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        // Reset over populated state with a write in flight
        do_reset();
        for (int x = 0; x < 8; x++) idle(3'(x), 3'(7 - x));
        idle(3'd3, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
